// File: rtl/eth_crc_pkg.sv
// rtl/eth_crc_pkg.sv - CRC-32 constants, FSM state type and bit-serial step function
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2
  } crc_state_t;

  // Reflected CRC: bit 0 of the data is the first bit on the wire
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [7:0]  data,
                                             input int          width);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (i < width) begin
        c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_step.sv
// rtl/eth_crc32_step.sv - combinational CRC-32 update for one DW-bit beat
module eth_crc32_step
  import eth_crc_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [31:0]   i_crc,
  input  logic [DW-1:0] i_data,
  output logic [31:0]   o_crc
);

  logic [7:0] w_data;

  assign w_data = 8'(i_data);
  assign o_crc  = crc32_step(i_crc, w_data, DW);

endmodule

// File: rtl/eth_crc32_engine.sv
// rtl/eth_crc32_engine.sv - streaming Ethernet CRC-32 engine: TX appends FCS, RX checks residue
module eth_crc32_engine
  import eth_crc_pkg::*;
#(
  parameter int DW   = 4,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [31:0]   crc_value,
  output logic          chk_done,
  output logic          chk_ok
);

  localparam int         NBEATS   = 32 / DW;
  localparam logic [3:0] ALL_IDX  = 4'(NBEATS);
  localparam logic [3:0] LAST_IDX = 4'(NBEATS - 1);

  crc_state_t    r_state;
  logic [31:0]   r_crc;
  logic [3:0]    r_fcs_cnt;
  logic          r_rdy_en;
  logic          r_m_valid;
  logic [DW-1:0] r_m_data;
  logic          r_m_last;
  logic          r_chk_done;
  logic          r_chk_ok;

  logic [31:0]   w_crc_next;
  logic [DW-1:0] w_fcs_beat;
  logic          w_slice_free;
  logic          w_accept;

  eth_crc32_step #(.DW(DW)) u_step (
    .i_crc  (r_crc),
    .i_data (s_data),
    .o_crc  (w_crc_next)
  );

  assign w_slice_free = ~r_m_valid | m_ready;
  assign s_ready      = r_rdy_en & (r_state != FCS) & w_slice_free;
  assign w_accept     = s_valid & s_ready;
  assign w_fcs_beat   = DW'(~r_crc >> (r_fcs_cnt * DW));

  // r_fcs_cnt counts FCS beats loaded into the slice; ALL_IDX means the last one is waiting to be taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_crc      <= CRC32_INIT;
      r_fcs_cnt  <= '0;
      r_rdy_en   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_chk_done <= 1'b0;
      r_chk_ok   <= 1'b0;
    end else begin
      r_rdy_en   <= 1'b1;
      r_chk_done <= 1'b0;
      if (clr) begin
        r_state   <= IDLE;
        r_crc     <= CRC32_INIT;
        r_fcs_cnt <= '0;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else if (r_state == FCS) begin
        if (r_fcs_cnt == ALL_IDX) begin
          if (m_ready) begin
            r_state   <= IDLE;
            r_crc     <= CRC32_INIT;
            r_fcs_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end
        end else if (w_slice_free) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_fcs_beat;
          r_m_last  <= (r_fcs_cnt == LAST_IDX);
          r_fcs_cnt <= r_fcs_cnt + 4'd1;
        end
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_data;
        r_m_last  <= (MODE != 0) & s_last;
        if (!s_last) begin
          r_state <= DATA;
          r_crc   <= w_crc_next;
        end else if (MODE == 0) begin
          r_state   <= FCS;
          r_crc     <= w_crc_next;
          r_fcs_cnt <= '0;
        end else begin
          r_state    <= IDLE;
          r_crc      <= CRC32_INIT;
          r_chk_done <= 1'b1;
          r_chk_ok   <= (w_crc_next == CRC32_RESIDUE);
        end
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign crc_value = r_crc;
  assign chk_done  = r_chk_done;
  assign chk_ok    = r_chk_ok;

endmodule
